// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM reading opcode/operand bytes from a registered RAM.
// Define FETCH_OPERAND_EN to fetch the memory operand for LDA/ADD/SUB.
module fetch_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic [3:0] ram_address,
    output logic       ram_read_enable,
    output logic       ram_write_enable,
    input  logic [7:0] ram_data,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [3:0] opcode,
    output logic [7:0] operand,
    output logic [3:0] pc,
    output logic       halted
);
    typedef enum logic [2:0] {
        IDLE, I_ADDR, I_READ, DECODE,
`ifdef FETCH_OPERAND_EN
        O_ADDR, O_READ,
`endif
        ISSUE, HALT
    } state_t;
    state_t state, next;
    logic [7:0] ir;
    logic rd_i, rd_o;
    assign rd_i = (state == I_ADDR) || (state == I_READ);
`ifdef FETCH_OPERAND_EN
    logic mem_op;
    assign mem_op = (ir[7:4] == 4'h1) || (ir[7:4] == 4'h2) || (ir[7:4] == 4'h3);
    assign rd_o = (state == O_ADDR) || (state == O_READ);
`else
    assign rd_o = 1'b0;
`endif
    assign ram_read_enable = rd_i || rd_o;
    assign ram_address = rd_i ? pc : rd_o ? ir[3:0] : 4'h0;
    assign ram_write_enable = 1'b0;
    assign instr_valid = state == ISSUE;
    assign halted = state == HALT;
    assign opcode = ir[7:4];
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = run ? I_ADDR : IDLE;
            I_ADDR:  next = I_READ;
            I_READ:  next = DECODE;
`ifdef FETCH_OPERAND_EN
            DECODE:  next = mem_op ? O_ADDR : ISSUE;
            O_ADDR:  next = O_READ;
            O_READ:  next = ISSUE;
`else
            DECODE:  next = ISSUE;
`endif
            ISSUE:   next = !instr_ready ? ISSUE : (ir[7:4] == 4'hF) ? HALT : run ? I_ADDR : IDLE;
            HALT:    next = HALT;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= 4'h0;
            ir      <= 8'h00;
            operand <= 8'h00;
        end else begin
            state <= next;
            if (state == I_READ) begin
                ir <= ram_data;
                pc <= pc + 4'h1;
            end
            // immediate operand; a memory fetch overwrites it before ISSUE
            if (state == DECODE) operand <= {4'b0000, ir[3:0]};
`ifdef FETCH_OPERAND_EN
            if (state == O_READ) operand <= ram_data;
`endif
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a registered RAM model.
module tb_fetch_unit;
    logic clk = 0, rst = 1, run = 0, instr_ready = 0;
    logic [3:0] ram_address, opcode, pc;
    logic ram_read_enable, ram_write_enable, instr_valid, halted;
    logic [7:0] ram_data, operand;
    logic [7:0] mem [16];
    logic [7:0] ram_q = 8'h00;
    int cyc = 0;
    int nchk = 0, nfail = 0;
`ifdef FETCH_OPERAND_EN
    localparam bit M = 1'b1;
`else
    localparam bit M = 1'b0;
`endif
    typedef struct {
        logic [3:0] op;
        logic [7:0] opd;
        logic [3:0] pc;
        int t;
    } exp_t;
    exp_t q[$];

    fetch_unit dut (
        .clk(clk), .rst(rst), .run(run),
        .ram_address(ram_address), .ram_read_enable(ram_read_enable),
        .ram_write_enable(ram_write_enable), .ram_data(ram_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .operand(operand), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ram_read_enable) ram_q <= mem[ram_address];
    assign ram_data = ram_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] opd, input logic [3:0] p, input int t);
        exp_t e;
        e.op = op; e.opd = opd; e.pc = p; e.t = t;
        q.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr"}, ram_address, 0);
        chk({tag, "_rd_en"}, ram_read_enable, 0);
        chk({tag, "_wr_en"}, ram_write_enable, 0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_opcode"}, opcode, 0);
        chk({tag, "_operand"}, operand, 0);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_halted"}, halted, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1; run = 0;
        tick();
        check_reset(tag);
        rst = 0;
    endtask

    // monitor: every accepted instruction is matched against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && instr_valid && instr_ready) begin
            if (q.size() == 0) chk("unexpected_issue", 1, 0);
            else begin
                e = q.pop_front();
                chk("issue_opcode", opcode, e.op);
                chk("issue_operand", operand, e.opd);
                chk("issue_pc", pc, e.pc);
                if (e.t >= 0) chk("issue_cycle", cyc, e.t);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, t, n;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        // program: LDA 12, ADD 5, E0, HLT
        mem[0] = 8'h1C; mem[1] = 8'h25; mem[2] = 8'hE0; mem[3] = 8'hF0;
        mem[5] = 8'h77; mem[12] = 8'h01;
        do_reset("reset0");
        instr_ready = 1; run = 1;
        e = cyc + 1;
        t = e + (M ? 5 : 3);
        push(4'h1, M ? 8'h01 : 8'h0C, 4'h1, t);
        t = t + (M ? 6 : 4);
        push(4'h2, M ? 8'h77 : 8'h05, 4'h2, t);
        t = t + 4;
        push(4'hE, 8'h00, 4'h3, t);
        t = t + 4;
        push(4'hF, 8'h00, 4'h4, t);
        n = 0;
        while (!halted && n < 100) begin tick(); n++; end
        chk("halt_reached", halted, 1);
        repeat (20) begin
            tick();
            chk("halt_rd_en", ram_read_enable, 0);
            chk("halt_stays", halted, 1);
            chk("halt_valid", instr_valid, 0);
        end
        chk("queue_empty_prog", q.size(), 0);

        // backpressure: ready low for 5 cycles in ISSUE
        mem[0] = 8'h3A; mem[10] = 8'h5B;
        instr_ready = 0;
        do_reset("reset1");
        run = 1;
        push(4'h3, M ? 8'h5B : 8'h0A, 4'h1, -1);
        n = 0;
        while (!instr_valid && n < 50) begin tick(); n++; end
        chk("hold_valid_seen", instr_valid, 1);
        repeat (5) begin
            tick();
            chk("hold_valid", instr_valid, 1);
            chk("hold_opcode", opcode, 4'h3);
            chk("hold_operand", operand, M ? 8'h5B : 8'h0A);
        end
        run = 0; instr_ready = 1;
        tick();
        repeat (6) begin
            tick();
            chk("hold_single_issue", instr_valid, 0);
            chk("hold_idle_rd_en", ram_read_enable, 0);
        end
        chk("queue_empty_hold", q.size(), 0);

        // pc wrap: fifteen immediates then ADD 14 fetched from address 15
        for (int i = 0; i < 15; i++) mem[i] = 8'(i);
        mem[15] = 8'h2E;
        do_reset("reset2");
        instr_ready = 1; run = 1;
        e = cyc + 1;
        t = e + 3;
        for (int i = 0; i < 15; i++) begin
            push(4'h0, 8'(i), 4'(i + 1), t);
            t = t + 4;
        end
        push(4'h2, 8'h0E, 4'h0, t + (M ? 2 : 0));
        n = 0;
        while (q.size() != 0 && n < 300) begin tick(); n++; end
        chk("wrap_all_issued", q.size(), 0);
        instr_ready = 0; run = 0;

        // reset during the operand read
        mem[0] = 8'h1C; mem[12] = 8'h01;
        do_reset("reset3");
        instr_ready = 1; run = 1;
        e = cyc + 1;
        if (!M) push(4'h1, 8'h0C, 4'h1, e + 3);
        repeat (5) tick();
        chk("midread_rd_en", ram_read_enable, 1);
        chk("midread_addr", ram_address, M ? 4'hC : 4'h1);
        chk("midread_pc", pc, 4'h1);
        rst = 1;
        tick();
        check_reset("rst_midread");
        rst = 0; run = 0;
        repeat (3) begin
            tick();
            chk("post_rst_idle_rd_en", ram_read_enable, 0);
            chk("post_rst_valid", instr_valid, 0);
        end
        chk("queue_empty_final", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-003 SHALL have port run  input  1  permit fetching; sampled in IDLE and on issue handshake.
REQ-004 SHALL have port ram_address  output  4  RAM word address.
REQ-005 SHALL have port ram_read_enable  output  1  RAM read strobe.
REQ-006 SHALL have port ram_write_enable  output  1  RAM write strobe; constant 0.
REQ-007 SHALL have port ram_data  input  8  RAM data bus, read side; registered RAM data valid one cycle after the address is presented.
REQ-008 SHALL have port instr_valid  output  1  instruction available downstream.
REQ-009 SHALL have port instr_ready  input  1  downstream accepts instruction.
REQ-010 SHALL have port opcode  output  4  instruction upper nibble.
REQ-011 SHALL have port operand  output  8  operand value.
REQ-012 SHALL have port pc  output  4  address of the next instruction.
REQ-013 SHALL have port halted  output  1  HLT accepted; fetching stopped.

Function
REQ-014 SHALL implement FSM states IDLE, I_ADDR, I_READ, DECODE, O_ADDR, O_READ, ISSUE, HALT.
REQ-015 SHALL, in IDLE, stay in IDLE while run=0 and go to I_ADDR when run=1.
REQ-016 SHALL, in I_ADDR and I_READ, drive ram_address=pc and ram_read_enable=1.
REQ-017 SHALL, on the I_READ exit edge, load ir<=ram_data and increment pc modulo 16 (15 wraps to 0).
REQ-018 SHALL, from DECODE, go to O_ADDR for opcodes 0001 (LDA), 0010 (ADD) and 0011 (SUB) when operand fetch is enabled; otherwise go to ISSUE with operand={4'b0000, ir[3:0]}.
REQ-019 SHALL, in O_ADDR and O_READ, drive ram_address=ir[3:0] and ram_read_enable=1.
REQ-020 SHALL, on the O_READ exit edge, load operand<=ram_data, then go to ISSUE.
REQ-021 SHALL drive ram_read_enable=0 in IDLE, DECODE, ISSUE and HALT.
REQ-022 SHALL assert instr_valid only in ISSUE.
REQ-023 SHALL hold opcode and operand stable while instr_valid=1 and instr_ready=0.
REQ-024 SHALL, on an ISSUE edge with instr_ready=1, go to:
- HALT if opcode=1111;
- else I_ADDR if run=1;
- else IDLE.
REQ-025 SHALL set halted=1 in HALT and remain in HALT until rst.
REQ-026 SHALL ignore instr_ready outside ISSUE.
REQ-027 SHALL, for a non-memory instruction, assert instr_valid 4 edges after run is sampled high in IDLE; for a memory-reference instruction, 6 edges.
REQ-028 SHALL, with instr_ready held high, issue back-to-back instructions every 4 cycles (non-memory) or 6 cycles (memory-reference).

Reset
REQ-029 SHALL, when rst=1 at a clock edge, force state=IDLE, pc=0, ir=0, operand=0, opcode=0, instr_valid=0, halted=0, ram_read_enable=0, ram_write_enable=0 and ram_address=0, regardless of current state (including mid-read or HALT).
REQ-030 SHALL give rst priority over run and instr_ready in the same cycle.

Configuration
REQ-031 SHALL, with macro FETCH_OPERAND_EN defined, perform the O_ADDR/O_READ operand fetch for opcodes 0001/0010/0011.
REQ-032 SHALL, without FETCH_OPERAND_EN, omit the O_ADDR/O_READ states, return operand={4'b0000, ir[3:0]} for all opcodes, and use 4-cycle issue for every instruction.

Verification
REQ-033 SHALL cover: RAM[0]=0x1C, RAM[12]=0x01, macro on, run=1, ready=1 -> first issue opcode=1, operand=0x01, pc=1, valid 6 edges after run.
REQ-034 SHALL cover: RAM[2]=0xE0 -> issue opcode=E, operand=0x00, 4-cycle spacing from previous issue.
REQ-035 SHALL cover: RAM[3]=0xF0, ready=1 -> opcode=F issued once, then halted=1, ram_read_enable stays 0 for 20 cycles.
REQ-036 SHALL cover: ready held 0 for 5 cycles in ISSUE -> instr_valid, opcode and operand constant; single issue on release.
REQ-037 SHALL cover: pc=15, fetch completes -> pc=0; rst asserted in O_READ -> next cycle IDLE, all outputs at reset values.
REQ-038 SHALL cover: macro off, RAM[0]=0x1C -> operand=0x0C, valid 4 edges after run.
